// File: rtl/game_controller.sv
`timescale 1ns/1ps
// Breakout frame sequencer: owns paddle, brick, lives, score and the game-state FSM.
// Updates once per frame tick (rising edge of y==481,x==0); ball events accepted any cycle, all outputs registered.
module game_controller #(
    parameter int X_MAX        = 639,
    parameter int BOARD_WIDTH  = 64,
    parameter int BOARD_Y      = 440,
    parameter int BOARD_STEP   = 4,
    parameter int BRICK_Y      = 60,
    parameter int BRICK_X0     = 40,
    parameter int BRICK_PITCH  = 110,
    parameter int BRICK_COLS   = 5,
    parameter int LIVES_INIT   = 3,
    parameter int WIN_SCORE    = 10,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic       brick_hit,
    input  logic       ball_lost,
    output logic [9:0] board_x,
    output logic [9:0] board_y,
    output logic [9:0] brick_x,
    output logic [9:0] brick_y,
    output logic       brick_visible,
    output logic       ball_hold,
    output logic [1:0] lives,
    output logic [3:0] score,
    output logic [2:0] state
);
    localparam int BX_MAX  = X_MAX + 1 - BOARD_WIDTH;
    localparam int BX_INIT = BX_MAX / 2;
    localparam int IW      = $clog2(BRICK_COLS + 1);
    localparam int CW      = $clog2(SERVE_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } state_t;

    state_t        state_q, state_n;
    logic          tick_prev, start_prev;
    logic          tick_raw, tick, start_rise;
    logic [IW-1:0] idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [9:0]    bx_n;
    logic          vis_n;
    logic [1:0]    lives_n;
    logic [3:0]    score_n;

    // x dwells at 0 for several clocks, so only the first cycle of the match is a tick
    assign tick_raw   = (y == 10'd481) && (x == 10'd0);
    assign tick       = tick_raw && !tick_prev;
    assign start_rise = btn_start && !start_prev;

    assign board_y = 10'(BOARD_Y);
    assign brick_y = 10'(BRICK_Y);
    assign state   = state_q;

    always_comb begin
        state_n = state_q;
        bx_n    = board_x;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        vis_n   = brick_visible;
        lives_n = lives;
        score_n = score;

        if (tick && (state_q == SERVE || state_q == PLAY)) begin
            if (btn_left && !btn_right)
                bx_n = (board_x < 10'(BOARD_STEP)) ? 10'd0 : board_x - 10'(BOARD_STEP);
            else if (btn_right && !btn_left)
                bx_n = (board_x > 10'(BX_MAX - BOARD_STEP)) ? 10'(BX_MAX)
                                                            : board_x + 10'(BOARD_STEP);
        end

        case (state_q)
            IDLE: begin
                vis_n = 1'b0;
                if (start_rise) begin
                    state_n = SERVE;
                    lives_n = 2'(LIVES_INIT);
                    score_n = 4'd0;
                    idx_n   = '0;
                    vis_n   = 1'b1;
                end
            end
            SERVE: begin
                if (tick) begin
                    vis_n = 1'b1;
                    if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        state_n = PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                // a lost ball outranks a same-cycle hit; a hit on a blanked brick is dropped
                if (ball_lost) begin
                    state_n = LOST;
                end else if (brick_hit && brick_visible) begin
                    score_n = (score == 4'hf) ? 4'hf : score + 4'd1;
                    vis_n   = 1'b0;
                    idx_n   = (idx_q == IW'(BRICK_COLS - 1)) ? '0 : idx_q + 1'b1;
                    if (int'(score_n) >= WIN_SCORE)
                        state_n = WIN;
                end else if (tick) begin
                    vis_n = 1'b1;
                end
            end
            LOST: begin
                lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                if (lives_n == 2'd0) begin
                    state_n = OVER;
                    vis_n   = 1'b0;
                end else begin
                    state_n = SERVE;
                end
            end
            OVER, WIN: begin
                vis_n = 1'b0;
                if (start_rise)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tick_prev     <= 1'b0;
            start_prev    <= 1'b0;
            idx_q         <= '0;
            cnt_q         <= '0;
            board_x       <= 10'(BX_INIT);
            brick_x       <= 10'(BRICK_X0);
            brick_visible <= 1'b0;
            ball_hold     <= 1'b1;
            lives         <= 2'(LIVES_INIT);
            score         <= 4'd0;
        end else begin
            state_q       <= state_n;
            tick_prev     <= tick_raw;
            start_prev    <= btn_start;
            idx_q         <= idx_n;
            cnt_q         <= cnt_n;
            board_x       <= bx_n;
            brick_x       <= 10'(BRICK_X0 + int'(idx_n) * BRICK_PITCH);
            brick_visible <= vis_n;
            ball_hold     <= (state_n != PLAY);
            lives         <= lives_n;
            score         <= score_n;
        end
    end
endmodule

// File: tb/tb_game_controller.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for game_controller against a rule-level game model.
module tb_game_controller;
    logic       clk, reset_n;
    logic [9:0] x, y;
    logic       btn_left, btn_right, btn_start, brick_hit, ball_lost;
    logic [9:0] board_x, board_y, brick_x, brick_y;
    logic       brick_visible, ball_hold;
    logic [1:0] lives;
    logic [3:0] score;
    logic [2:0] state;

    game_controller dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y),
        .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
        .brick_hit(brick_hit), .ball_lost(ball_lost),
        .board_x(board_x), .board_y(board_y), .brick_x(brick_x), .brick_y(brick_y),
        .brick_visible(brick_visible), .ball_hold(ball_hold),
        .lives(lives), .score(score), .state(state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] brx;
        logic [9:0] bry;
        logic       vis;
        logic       hold;
        logic [1:0] lv;
        logic [3:0] sc;
    } obs_t;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_LOST = 3, M_OVER = 4, M_WIN = 5;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t expq[$];
    bit   hold_rst = 1'b1;

    // game model, in plain game terms
    int m_mode, m_bx, m_col, m_vis, m_lives, m_score, m_frames;
    bit m_raw_prev, m_start_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t sample();
        return '{state, board_x, board_y, brick_x, brick_y, brick_visible, ball_hold, lives, score};
    endfunction

    function automatic obs_t expected();
        return '{3'(m_mode), 10'(m_bx), 10'd440, 10'(40 + 110 * m_col), 10'd60,
                 m_vis != 0, m_mode != M_PLAY, 2'(m_lives), 4'(m_score)};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got st=%0d bx=%0d by=%0d brx=%0d bry=%0d vis=%0d hold=%0d lives=%0d score=%0d, required st=%0d bx=%0d by=%0d brx=%0d bry=%0d vis=%0d hold=%0d lives=%0d score=%0d",
                     name, $time, got.st, got.bx, got.by, got.brx, got.bry, got.vis, got.hold, got.lv, got.sc,
                     exp.st, exp.bx, exp.by, exp.brx, exp.bry, exp.vis, exp.hold, exp.lv, exp.sc);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_bx = 288; m_col = 0; m_vis = 0; m_lives = 3; m_score = 0;
        m_frames = 0; m_raw_prev = 1'b0; m_start_prev = 1'b0;
    endtask

    task automatic model_step(input bit raw, input bit l, input bit r, input bit s,
                              input bit hit, input bit lost);
        bit new_frame, pressed;
        new_frame    = raw && !m_raw_prev;
        pressed      = s && !m_start_prev;
        m_raw_prev   = raw;
        m_start_prev = s;
        if (new_frame && (m_mode == M_SERVE || m_mode == M_PLAY)) begin
            if (l && !r) m_bx = (m_bx - 4 < 0) ? 0 : m_bx - 4;
            if (r && !l) m_bx = (m_bx + 4 > 576) ? 576 : m_bx + 4;
        end
        case (m_mode)
            M_IDLE: if (pressed) begin
                m_mode = M_SERVE; m_lives = 3; m_score = 0; m_col = 0; m_vis = 1;
            end
            M_SERVE: if (new_frame) begin
                m_vis = 1;
                m_frames++;
                if (m_frames == 60) begin m_mode = M_PLAY; m_frames = 0; end
            end
            M_PLAY: begin
                if (lost) m_mode = M_LOST;
                else if (hit && m_vis != 0) begin
                    m_score = (m_score + 1 > 15) ? 15 : m_score + 1;
                    m_vis = 0;
                    m_col = (m_col + 1) % 5;
                    if (m_score >= 10) m_mode = M_WIN;
                end else if (new_frame) m_vis = 1;
            end
            M_LOST: begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                if (m_lives == 0) begin m_mode = M_OVER; m_vis = 0; end
                else m_mode = M_SERVE;
            end
            default: if (pressed) m_mode = M_IDLE;
        endcase
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic cyc(input bit raw, input bit l, input bit r, input bit s,
                       input bit hit, input bit lost);
        @(negedge clk);
        reset_n = !hold_rst;
        if (raw) begin
            x = 10'd0; y = 10'd481;
        end else begin
            y = 10'($urandom_range(0, 520));
            if (y == 10'd481) y = 10'd482;
            x = 10'($urandom_range(0, 799));
        end
        btn_left = l; btn_right = r; btn_start = s; brick_hit = hit; ball_lost = lost;
        if (hold_rst) model_reset();
        else model_step(raw, l, r, s, hit, lost);
        expq.push_back(expected());
    endtask

    // one frame: 1-4 clocks at the tick position, then 1-3 clocks elsewhere
    task automatic frame(input bit l, input bit r, input bit s, input int hp, input int lp);
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) cyc(1'b1, l, r, s, pct(hp), pct(lp));
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) cyc(1'b0, l, r, s, pct(hp), pct(lp));
    endtask

    task automatic serve_frames();
        repeat (60) frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", sample(), expected());
        hold_rst = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold_rst = 1'b0;
    endtask

    // monitor: every cycle the DUT presents registered outputs, pop and compare
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) check("cycle", sample(), expq.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; x = 10'd0; y = 10'd0;
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
        model_reset();
        do_reset();

        repeat (3) frame(1'b1, 1'b0, 1'b0, 30, 30);      // IDLE ignores paddle and events
        repeat (4) frame(1'b0, 1'b0, 1'b1, 0, 0);        // held start enters SERVE once
        serve_frames();
        repeat (80)  frame(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (200) frame(1'b0, 1'b1, 1'b0, 0, 0);
        repeat (20)  frame(1'b1, 1'b1, 1'b0, 0, 0);

        repeat (5) begin
            frame(1'b0, 1'b0, 1'b0, 0, 0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // blanked brick, ignored
        end
        frame(1'b0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);       // lost wins over hit
        serve_frames();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        serve_frames();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);       // last life -> OVER
        repeat (3) frame(1'b0, 1'b0, 1'b0, 40, 40);
        repeat (5) frame(1'b0, 1'b0, 1'b1, 0, 0);      // held start -> IDLE only
        frame(1'b0, 1'b0, 1'b0, 0, 0);
        frame(1'b0, 1'b0, 1'b1, 0, 0);
        serve_frames();
        repeat (10) begin
            frame(1'b0, 1'b0, 1'b0, 0, 0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        repeat (3) frame(1'b1, 1'b0, 1'b0, 50, 50);    // WIN is frozen
        frame(1'b0, 1'b0, 1'b1, 0, 0);
        frame(1'b0, 1'b0, 1'b0, 0, 0);

        for (int g = 0; g < 4; g++) begin
            frame(1'b0, 1'b0, 1'b1, 0, 0);
            frame(1'b0, 1'b0, 1'b0, 0, 0);
            for (int f = 0; f < 400 && m_mode != M_OVER && m_mode != M_WIN; f++)
                frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) == 0), 8, 2);
            frame(1'b0, 1'b0, 1'b0, 0, 0);
            frame(1'b0, 1'b0, 1'b1, 0, 0);
            frame(1'b0, 1'b0, 1'b0, 0, 0);
        end

        frame(1'b0, 1'b0, 1'b1, 0, 0);
        serve_frames();
        repeat (47) frame(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (3) begin
            frame(1'b0, 1'b0, 1'b0, 0, 0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        do_reset();                                    // abort mid-PLAY
        repeat (3) frame(1'b0, 1'b1, 1'b0, 20, 20);

        repeat (3) @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
